// File: rtl/ring_capture_pkg.sv
// Shared types and width helpers for the ring capture buffer.
package ring_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_TRIG,
    POST,
    READ
  } state_t;

  localparam int unsigned ADDR_W_DEFAULT = 10;

  // Width of address arithmetic that must hold values up to 2*DEPTH-1.
  function automatic int unsigned arith_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/ring_capture_ram.sv
// Simple dual-port ring storage: one write port, one read port with a registered output.
module ring_capture_ram #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned DEPTH  = 1000,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge wr_clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n)  rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ring_capture_buffer.sv
// Trigger-aligned circular capture buffer with chronological valid/ready drain.
// Define RING_CAPTURE_TRIG_EDGE_EN for rising-edge trigger qualification (default: level).
module ring_capture_buffer
  import ring_capture_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CH_NUM = 2,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DEPTH  = 1000
) (
  input  logic                     wr_clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [CH_NUM*DATA_W-1:0] din,
  input  logic                     arm,
  input  logic                     trig,
  input  logic [ADDR_W-1:0]        pre_len,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [CH_NUM*DATA_W-1:0] dout,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     triggered
);

  localparam int unsigned WORD_W = CH_NUM * DATA_W;
  localparam int unsigned AW1    = arith_w(ADDR_W);
  localparam logic [AW1-1:0]    DEPTH_X   = AW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pre_q, fill_cnt, wr_addr, trig_addr, rd_addr;
  logic [ADDR_W-1:0] pre_clamp, start_addr;
  logic [AW1-1:0]    post_cnt, post_len, rd_cnt, start_sum, start_fix;
  logic              addr_ok, trig_qual, trig_fire, ram_we, ram_re;

  assign pre_clamp = ({1'b0, pre_len} > DEPTH_X - AW1'(1)) ? LAST_ADDR : pre_len;
  assign post_len  = DEPTH_X - {1'b0, pre_q};

  // Oldest word of the window sits pre_q entries before the trigger sample.
  assign start_sum  = {1'b0, trig_addr} + DEPTH_X - {1'b0, pre_q};
  assign start_fix  = (start_sum >= DEPTH_X) ? start_sum - DEPTH_X : start_sum;
  assign start_addr = start_fix[ADDR_W-1:0];

`ifdef RING_CAPTURE_TRIG_EDGE_EN
  logic trig_hist;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n)
      trig_hist <= 1'b0;
    else if (state_q == IDLE && arm)
      trig_hist <= 1'b0;
    else if (wr_en && state_q inside {FILL, WAIT_TRIG, POST})
      trig_hist <= trig;
  end

  assign trig_qual = trig & ~trig_hist;
`else
  assign trig_qual = trig;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    trig_fire = 1'b0;
    unique case (state_q)
      IDLE: if (arm) state_d = FILL;
      FILL: begin
        ram_we = wr_en;
        if (pre_q == '0 || (wr_en && fill_cnt + ADDR_W'(1) == pre_q))
          state_d = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        ram_we = wr_en;
        if (wr_en && trig_qual) begin
          trig_fire = 1'b1;
          state_d   = POST;
        end
      end
      POST: begin
        if (post_cnt == post_len) begin
          state_d = READ;
        end else begin
          ram_we = wr_en;
          if (wr_en && post_cnt + AW1'(1) == post_len) state_d = READ;
        end
      end
      READ: if (rd_valid && rd_ready && rd_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A read is issued only when the output register is empty or draining this cycle.
  assign ram_re = (state_q == READ) && addr_ok && (rd_cnt != DEPTH_X) &&
                  (!rd_valid || rd_ready);

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      fill_cnt  <= '0;
      wr_addr   <= '0;
      trig_addr <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
    end else begin
      if (state_q == IDLE && arm) begin
        pre_q    <= pre_clamp;
        fill_cnt <= '0;
        wr_addr  <= '0;
        post_cnt <= '0;
      end
      if (ram_we) wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
      if (state_q == FILL && wr_en) fill_cnt <= fill_cnt + ADDR_W'(1);
      if (trig_fire) begin
        trig_addr <= wr_addr;
        post_cnt  <= AW1'(1);
        triggered <= 1'b1;
      end else begin
        if (state_q == POST && ram_we) post_cnt <= post_cnt + AW1'(1);
        if (state_d == IDLE) triggered <= 1'b0;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ok  <= 1'b0;
      rd_addr  <= '0;
      rd_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else if (state_q != READ) begin
      addr_ok  <= 1'b0;
      rd_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (!addr_ok) begin
        rd_addr <= start_addr;
        addr_ok <= 1'b1;
      end else if (ram_re) begin
        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
      end
      if (ram_re) begin
        rd_cnt   <= rd_cnt + AW1'(1);
        rd_valid <= 1'b1;
        rd_last  <= (rd_cnt == DEPTH_X - AW1'(1));
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

  ring_capture_ram #(
    .WIDTH  (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .wr_clk  (wr_clk),
    .rst_n   (rst_n),
    .we      (ram_we),
    .wr_addr (wr_addr),
    .wr_data (din),
    .re      (ram_re),
    .rd_addr (rd_addr),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_ring_capture_buffer.sv
// Directed bench for ring_capture_buffer at DEPTH=16; ramp samples, hand-derived windows.
module tb_ring_capture_buffer;

  localparam int DATA_W = 12;
  localparam int CH_NUM = 2;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;
  localparam int W      = CH_NUM * DATA_W;

  logic              wr_clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [W-1:0]      din;
  logic              arm;
  logic              trig;
  logic [ADDR_W-1:0] pre_len;
  logic              rd_ready;
  logic              rd_valid;
  logic [W-1:0]      dout;
  logic              rd_last;
  logic              busy;
  logic              triggered;

  int total = 0;
  int bad   = 0;

  ring_capture_buffer #(
    .DATA_W (DATA_W),
    .CH_NUM (CH_NUM),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .wr_clk    (wr_clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .din       (din),
    .arm       (arm),
    .trig      (trig),
    .pre_len   (pre_len),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .dout      (dout),
    .rd_last   (rd_last),
    .busy      (busy),
    .triggered (triggered)
  );

  always #5 wr_clk = ~wr_clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Sample k carries k on channel 0 and k+0x100 on channel 1.
  function automatic logic [W-1:0] word_of(input int k);
    logic [DATA_W-1:0] c0, c1;
    c0 = DATA_W'(k);
    c1 = DATA_W'(k + 'h100);
    return {c1, c0};
  endfunction

  task automatic check_all_zero(input string tag);
    total++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0 || busy !== 1'b0 ||
        triggered !== 1'b0 || dout !== '0) begin
      bad++;
      $display("FAIL %s: valid=%b last=%b busy=%b trig=%b dout=%h, required all 0",
               tag, rd_valid, rd_last, busy, triggered, dout);
    end
  endtask

  // One full capture: arm, ramp samples with a trig pattern, drain and check the window.
  // trig(k) = (k < hi_until) || (k == trig_k); exp_t is the sample the DUT must accept.
  task automatic run_capture(input string name, input int pre, input int hi_until,
                             input int trig_k, input int exp_t, input int exp_pre,
                             input bit bp, input int abort_after);
    bit done;
    int first;
    done  = 1'b0;
    first = exp_t - exp_pre;

    @(negedge wr_clk);
    arm     = 1'b1;
    pre_len = ADDR_W'(pre);
    @(negedge wr_clk);
    arm = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_after_arm: got %b want 1", name, busy);
    end

    fork
      begin : writer
        for (int k = 0; !done && k < 400; k++) begin
          wr_en = 1'b1;
          din   = word_of(k);
          trig  = (k < hi_until) || (k == trig_k);
          if (k == exp_t) begin
            total++;
            if (triggered !== 1'b0) begin
              bad++;
              $display("FAIL %s triggered_early: got %b want 0", name, triggered);
            end
          end
          @(negedge wr_clk);
          if (k == exp_t) begin
            total++;
            if (triggered !== 1'b1) begin
              bad++;
              $display("FAIL %s triggered_rise: got %b want 1", name, triggered);
            end
          end
        end
      end
      begin : reader
        int n;
        bit started, stall, rdy;
        logic [W-1:0] held;
        n = 0; started = 1'b0; stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
          @(negedge wr_clk);
          if (stall) begin
            total++;
            if (rd_valid !== 1'b1 || dout !== held) begin
              bad++;
              $display("FAIL %s hold_stable: valid=%b dout=%h want 1 %h", name, rd_valid, dout, held);
            end
          end
          if (!bp && started) begin
            total++;
            if (rd_valid !== 1'b1) begin
              bad++;
              $display("FAIL %s no_bubble: word %0d valid=%b want 1", name, n, rd_valid);
            end
          end
          if (rd_valid === 1'b1) started = 1'b1;
          rdy      = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
          rd_ready = rdy;
          stall    = (rd_valid === 1'b1) && !rdy;
          held     = dout;
          if (rd_valid === 1'b1 && rdy) begin
            total++;
            if (dout !== word_of(first + n)) begin
              bad++;
              $display("FAIL %s word[%0d]: got %h want %h", name, n, dout, word_of(first + n));
            end
            total++;
            if (rd_last !== (n == DEPTH - 1)) begin
              bad++;
              $display("FAIL %s last[%0d]: got %b want %b", name, n, rd_last, n == DEPTH - 1);
            end
            n++;
            if (n == DEPTH) begin
              done = 1'b1;
              @(negedge wr_clk);
              total++;
              if (busy !== 1'b0 || triggered !== 1'b0 || rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s end_idle: busy=%b trig=%b valid=%b want 0 0 0",
                         name, busy, triggered, rd_valid);
              end
            end else if (n == abort_after) begin
              rst_n = 1'b0;
              #1;
              check_all_zero({name, " reset_mid_read"});
              done = 1'b1;
            end
          end
        end
        if (!done) begin
          total++;
          bad++;
          $display("FAIL %s timeout: got %0d words want %0d", name, n, DEPTH);
          done = 1'b1;
        end
      end
    join

    wr_en    = 1'b0;
    trig     = 1'b0;
    rd_ready = 1'b1;
    if (rst_n === 1'b0) begin
      @(negedge wr_clk);
      check_all_zero({name, " held_in_reset"});
      rst_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; din = '0; arm = 1'b0; trig = 1'b0;
    pre_len = '0; rd_ready = 1'b1;
    #3;
    check_all_zero("reset_state");
    @(negedge wr_clk);
    rst_n = 1'b1;
    @(negedge wr_clk);
    check_all_zero("after_release");
  endtask

  task automatic test_basic();
    run_capture("basic", 4, 0, 20, 20, 4, 1'b0, -1);
  endtask

  task automatic test_pre_zero();
    // Sample 0 lands in FILL, so sample 1 is the first WAIT_TRIG sample.
    run_capture("pre_zero", 0, 0, 1, 1, 0, 1'b0, -1);
  endtask

  task automatic test_pre_clamp();
    run_capture("pre_clamp", 20, 0, 17, 17, 15, 1'b0, -1);
  endtask

  task automatic test_trig_held();
`ifdef RING_CAPTURE_TRIG_EDGE_EN
    run_capture("trig_held_edge", 5, 24, 27, 27, 5, 1'b0, -1);
`else
    run_capture("trig_held_level", 5, 24, 27, 5, 5, 1'b0, -1);
`endif
  endtask

  task automatic test_backpressure();
    run_capture("backpressure", 7, 0, 30, 30, 7, 1'b1, -1);
  endtask

  task automatic test_reset_mid_read();
    run_capture("abort", 4, 0, 20, 20, 4, 1'b0, 5);
    run_capture("after_abort", 3, 0, 18, 18, 3, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pre_zero();
    test_pre_clamp();
    test_trig_held();
    test_backpressure();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_capture_buffer.md
# ring_capture_buffer

Single-clock, multi-channel circular capture buffer for pre/post-trigger acquisition. Samples stream continuously into a ring of DEPTH entries once armed. A trigger freezes the ring after the post-trigger count completes. The frozen window is then drained in chronological order over a valid/ready port. It sits between the ADC sample front end and the display/upload logic, replacing free-running cyclic FIFOs wherever a trigger-aligned snapshot is needed.

## Interface
- DATA_W, 12: bits per channel sample
- CH_NUM, 2: channels packed per ring word (word width CH_NUM*DATA_W, channel 0 in LSBs)
- ADDR_W, 10: address width; requires DEPTH <= 2**ADDR_W
- DEPTH, 1000: ring length in words, 2..2**ADDR_W, need not be a power of two

- wr_clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  sample strobe; din valid this cycle
- din  in  CH_NUM*DATA_W  packed sample word
- arm  in  1  one-cycle pulse; starts a capture from IDLE
- trig  in  1  trigger qualifier, only sampled when wr_en=1
- pre_len  in  ADDR_W  pre-trigger word count, latched on arm
- rd_ready  in  1  downstream accepts dout
- rd_valid  out  1  dout valid
- dout  out  CH_NUM*DATA_W  captured word
- rd_last  out  1  marks final word of the window, qualified by rd_valid
- busy  out  1  state != IDLE
- triggered  out  1  high from trigger acceptance until return to IDLE

## Operation
- States: IDLE -> FILL -> WAIT_TRIG -> POST -> READ -> IDLE.
- IDLE:
  - arm=1 latches pre_q = min(pre_len, DEPTH-1).
  - Clears wr_addr and the fill counter, then enters FILL.
  - arm in any other state is ignored.
- FILL:
  - Each wr_en writes din to ram[wr_addr].
  - wr_addr advances and wraps at DEPTH-1 -> 0.
  - Transitions to WAIT_TRIG once pre_q words have been written. If pre_q=0, transitions immediately on the next cycle.
  - trig is ignored in FILL.
- WAIT_TRIG:
  - Writing continues with wraparound.
  - When wr_en=1 and trig is qualified (see Configuration), that sample is written, trig_addr is set to its address, and the state moves to POST.
  - The trigger sample counts as post-sample 1.
- POST:
  - Writing continues until DEPTH-pre_q post samples (including the trigger sample) are written, then the state moves to READ.
  - When DEPTH-pre_q = 1, the transition happens on the cycle after the trigger write.
- READ:
  - Writes are blocked and wr_en is ignored.
  - Read start address is (trig_addr + DEPTH - pre_q) mod DEPTH; address arithmetic is ADDR_W+1 bits wide, with one conditional subtract of DEPTH.
  - Exactly DEPTH words are emitted, wrapping at DEPTH-1 -> 0.
  - rd_last accompanies word DEPTH.
  - After the handshake on rd_last, the state returns to IDLE.
- Handshake:
  - A word transfers when rd_valid & rd_ready.
  - Once rd_valid rises, it and dout stay stable until the transfer.
  - There are no bubbles while rd_ready is held high.
- Reset, asynchronous and valid at any time including mid-READ:
  - State returns to IDLE.
  - rd_valid, rd_last, busy, triggered and dout all go to 0.
  - All counters and addresses go to 0.
  - RAM contents are not reset.

## Timing
- Ram is a synchronous-read, single-port-per-side block RAM. Write and read never overlap in time.
- arm at cycle N: busy=1 at N+1.
- Trigger write at cycle T: triggered=1 at T+1.
- From entering READ, the first rd_valid appears 2 cycles later (address register plus RAM output register).
- Sustained throughput is 1 word/cycle with rd_ready=1.
- Holding rd_ready=0 stalls the read pipeline: at most one word in flight plus the output register (skid of 1).
- After the rd_last handshake, busy=0 on the following cycle.

## Configuration
- RING_CAPTURE_TRIG_EDGE_EN defined:
  - trig is qualified on a rising edge, i.e. trig=1 with the previous wr_en-qualified trig value at 0.
  - The history register clears on arm and reset.
  - A trig held high since FILL does not fire.
- Undefined: trig is level-sensitive, so any wr_en & trig in WAIT_TRIG fires.

## Structure
- Shared package ring_capture_pkg holds:
  - the state enum: IDLE, FILL, WAIT_TRIG, POST, READ;
  - a helper constant for the ADDR_W+1 arithmetic width.
- One sub-module, ring_capture_ram: a parameterised DEPTH x (CH_NUM*DATA_W) RAM with registered read output.
- The FSM, counters and read handshake live in the top level.

## Test plan
- DEPTH=16, pre_len=4, ramp din=k on every wr_en, trigger at sample 20 -> reads 16..31 in order, rd_last on 31, busy falls after it.
- pre_len=0, trigger on the first WAIT_TRIG sample -> window starts exactly at the trigger sample.
- pre_len=20 with DEPTH=16 -> clamped to 15; exactly 1 post sample; window ends with the trigger sample.
- trig high during FILL, with the trigger sample index chosen so the ring wraps:
  - Edge mode: no trigger until trig toggles, then a correct wrapped window.
  - Level mode: fires on the first WAIT_TRIG wr_en.
- Random rd_ready backpressure during READ -> no dropped or duplicated words, and dout stays stable while rd_valid=1 and rd_ready=0.
- rst_n pulsed mid-READ, then a new arm -> all outputs 0 during reset, and the second capture completes correctly.
